// File: rtl/bpsk_demodulator_pkg.sv
// Shared definitions for the BPSK receive path: default geometry, sync states
// and the correlation accumulator sizing rule.
package bpsk_demodulator_pkg;

  localparam int SAMPLE_NUMBER_DEF = 256;
  localparam int SAMPLE_WIDTH_DEF  = 12;
  localparam int DATA_WIDTH_DEF    = 12;

  typedef enum logic {
    ST_UNSYNCED = 1'b0,
    ST_SYNCED   = 1'b1
  } sync_state_e;

  // Full-period sum of W x W signed products never overflows this width.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Three-stage multiply-accumulate pipeline correlating received samples with the
// reference sine; presents the finished period sum combinationally on sym_done.
module bpsk_correlator
  import bpsk_demodulator_pkg::*;
#(
  parameter int SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
  parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   en,
  input  logic                                                   take,
  input  logic [SAMPLE_WIDTH-1:0]                                signal_in,
  input  logic [SAMPLE_WIDTH-1:0]                                sine_ref,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0]                       cnt_in,
  output logic                                                   sym_done,
  output logic signed [acc_width(SAMPLE_NUMBER, SAMPLE_WIDTH)-1:0] sym_sum
);

  localparam int CNT_W  = $clog2(SAMPLE_NUMBER);
  localparam int PROD_W = 2 * SAMPLE_WIDTH;
  localparam int ACC_W  = acc_width(SAMPLE_NUMBER, SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_NUMBER - 1);

  logic                           s1_vld_r, s1_first_r, s1_last_r;
  logic signed [SAMPLE_WIDTH-1:0] s1_sig_r, s1_ref_r;
  logic                           s2_vld_r, s2_first_r, s2_last_r;
  logic signed [PROD_W-1:0]       s2_prod_r;
  logic signed [ACC_W-1:0]        acc_r, prod_ext_s, acc_next_s;

  // S1: offset-binary to two's complement (MSB flip) plus period markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_r   <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sig_r   <= {SAMPLE_WIDTH{1'b0}};
      s1_ref_r   <= {SAMPLE_WIDTH{1'b0}};
    end else if (en) begin
      s1_vld_r   <= take;
      s1_first_r <= (cnt_in == {CNT_W{1'b0}});
      s1_last_r  <= (cnt_in == CNT_LAST);
      s1_sig_r   <= {~signal_in[SAMPLE_WIDTH-1], signal_in[SAMPLE_WIDTH-2:0]};
      s1_ref_r   <= {~sine_ref[SAMPLE_WIDTH-1], sine_ref[SAMPLE_WIDTH-2:0]};
    end
  end

  // S2: signed product at full precision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_r   <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_prod_r  <= {PROD_W{1'b0}};
    end else if (en) begin
      s2_vld_r   <= s1_vld_r;
      s2_first_r <= s1_first_r;
      s2_last_r  <= s1_last_r;
      s2_prod_r  <= PROD_W'(s1_sig_r) * PROD_W'(s1_ref_r);
    end
  end

  // First sample of a period restarts the sum instead of adding to it.
  always_comb begin
    prod_ext_s = {{(ACC_W - PROD_W){s2_prod_r[PROD_W-1]}}, s2_prod_r};
    if (s2_first_r) begin
      acc_next_s = prod_ext_s;
    end else begin
      acc_next_s = acc_r + prod_ext_s;
    end
  end

  // S3: accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en && s2_vld_r) begin
      acc_r <= acc_next_s;
    end
  end

  assign sym_done = en & s2_vld_r & s2_last_r;
  assign sym_sum  = acc_next_s;

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK receiver: period sync, correlation, slicing with a low-confidence
// flag, and LSB-first reassembly of DATA_WIDTH-bit words.
module bpsk_demodulator
  import bpsk_demodulator_pkg::*;
#(
  parameter int SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
  parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int WEAK_THRESH   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [SAMPLE_WIDTH-1:0]          signal_in,
  input  logic [SAMPLE_WIDTH-1:0]          sine_ref,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic                             bit_out,
  output logic                             bit_valid,
  output logic                             sym_weak,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic                             data_weak
);

  localparam int CNT_W = $clog2(SAMPLE_NUMBER);
  localparam int ACC_W = acc_width(SAMPLE_NUMBER, SAMPLE_WIDTH);
  localparam int BC_W  = $clog2(DATA_WIDTH);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(WEAK_THRESH);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_WIDTH - 1);

  sync_state_e             sync_r, sync_next_s;
  logic                    take_s, sym_done_s, bit_s, weak_s, word_last_s, weak_word_s;
  logic signed [ACC_W-1:0] sym_sum_s;
  logic [ACC_W-1:0]        abs_s;
  logic [DATA_WIDTH-1:0]   shreg_r, word_next_s, data_out_r;
  logic [BC_W-1:0]         bit_cnt_r;
  logic                    weak_sticky_r, bit_out_r, bit_valid_r, sym_weak_r;
  logic                    data_valid_r, data_weak_r;

  // Until a period start is seen, samples are dropped so no partial period is sliced.
  always_comb begin
    sync_next_s = sync_r;
    take_s      = 1'b0;
    case (sync_r)
      ST_UNSYNCED: begin
        if (en && (cnt_in == {CNT_W{1'b0}})) begin
          sync_next_s = ST_SYNCED;
          take_s      = 1'b1;
        end else begin
          take_s      = 1'b0;
        end
      end
      ST_SYNCED: take_s = en;
      default:   sync_next_s = ST_UNSYNCED;
    endcase
  end

  // Sync state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= ST_UNSYNCED;
    end else begin
      sync_r <= sync_next_s;
    end
  end

  bpsk_correlator #(
    .SAMPLE_NUMBER (SAMPLE_NUMBER),
    .SAMPLE_WIDTH  (SAMPLE_WIDTH)
  ) u_corr (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .take      (take_s),
    .signal_in (signal_in),
    .sine_ref  (sine_ref),
    .cnt_in    (cnt_in),
    .sym_done  (sym_done_s),
    .sym_sum   (sym_sum_s)
  );

  // Slicer, confidence test and next shift-register image (new bit enters at the MSB).
  always_comb begin
    bit_s = ~sym_sum_s[ACC_W-1];
    if (sym_sum_s[ACC_W-1]) begin
      abs_s = $unsigned(-sym_sum_s);
    end else begin
      abs_s = $unsigned(sym_sum_s);
    end
    weak_s      = (abs_s <= THRESH_V);
    word_next_s = {bit_s, shreg_r[DATA_WIDTH-1:1]};
    word_last_s = (bit_cnt_r == BC_LAST);
    weak_word_s = weak_sticky_r | weak_s;
  end

  // Symbol outputs, word reassembly and word-level weak tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_out_r     <= 1'b0;
      bit_valid_r   <= 1'b0;
      sym_weak_r    <= 1'b0;
      data_out_r    <= {DATA_WIDTH{1'b0}};
      data_valid_r  <= 1'b0;
      data_weak_r   <= 1'b0;
      shreg_r       <= {DATA_WIDTH{1'b0}};
      bit_cnt_r     <= {BC_W{1'b0}};
      weak_sticky_r <= 1'b0;
    end else begin
      bit_valid_r  <= sym_done_s;
      data_valid_r <= sym_done_s & word_last_s;
      if (sym_done_s) begin
        bit_out_r  <= bit_s;
        sym_weak_r <= weak_s;
        shreg_r    <= word_next_s;
        if (word_last_s) begin
          data_out_r    <= word_next_s;
          data_weak_r   <= weak_word_s;
          bit_cnt_r     <= {BC_W{1'b0}};
          weak_sticky_r <= 1'b0;
        end else begin
          bit_cnt_r     <= bit_cnt_r + BC_W'(1);
          weak_sticky_r <= weak_word_s;
        end
      end
    end
  end

  assign bit_out    = bit_out_r;
  assign bit_valid  = bit_valid_r;
  assign sym_weak   = sym_weak_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign data_weak  = data_weak_r;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: a modulator model drives directed words,
// expectations (value and arrival cycle) are queued and a monitor pops them.
module tb_bpsk_demodulator;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] signal_in = 12'h800;
  logic [11:0] sine_ref = 12'h800;
  logic [7:0]  cnt_in = 8'd0;
  logic        bit_out, bit_valid, sym_weak, data_valid, data_weak;
  logic [11:0] data_out;

  bpsk_demodulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .signal_in  (signal_in),
    .sine_ref   (sine_ref),
    .cnt_in     (cnt_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .sym_weak   (sym_weak),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_weak  (data_weak)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit b; bit w; int rem;} pend_t;
  typedef struct {logic [11:0] v; bit w; int due;} exp_t;
  pend_t pend_q[$];
  exp_t  bit_q[$];
  exp_t  word_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  bit          synced_b = 1'b0;
  int          bitcnt_b = 0;
  logic [11:0] word_b = 12'h000;
  bit          wstick_b = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_of(input logic [7:0] c);
    real s;
    int  v;
    s = $sin(2.0 * 3.14159265358979 * real'(c) / 256.0);
    v = $rtoi($floor(2047.0 * s + 0.5));
    return 12'(2048 + v);
  endfunction

  // A symbol becomes visible; record its bit and, every 12th, the finished word.
  function automatic void resolve(input pend_t p, input int due);
    exp_t e;
    e.v = {11'd0, p.b}; e.w = p.w; e.due = due;
    bit_q.push_back(e);
    word_b[bitcnt_b] = p.b;
    wstick_b = wstick_b | p.w;
    if (bitcnt_b == 11) begin
      e.v = word_b; e.w = wstick_b; e.due = due;
      word_q.push_back(e);
      bitcnt_b = 0;
      wstick_b = 1'b0;
    end else begin
      bitcnt_b++;
    end
  endfunction

  // One sample slot. Expected output cycle = second en-high edge after the last sample.
  task automatic step(input bit e, input logic [11:0] sig, input logic [7:0] c,
                      input bit b, input bit w);
    pend_t p;
    @(negedge clk);
    en = e; signal_in = sig; sine_ref = ref_of(c); cnt_in = c;
    if (e) begin
      foreach (pend_q[i]) pend_q[i].rem--;
      while (pend_q.size() > 0 && pend_q[0].rem == 0) resolve(pend_q.pop_front(), cyc + 1);
      if (c == 8'd0) synced_b = 1'b1;
      if (synced_b && c == 8'(N - 1)) begin
        p.b = b; p.w = w; p.rem = 2;
        pend_q.push_back(p);
      end
    end
  endtask

  function automatic logic [11:0] mod_sample(input bit b, input logic [7:0] c);
    logic [11:0] r;
    r = ref_of(c);
    return b ? r : (12'h000 - r);
  endfunction

  task automatic send_symbol(input bit b, input bit stall_mid, input bit stall_last);
    for (int k = 0; k < N; k++) begin
      if ((stall_mid && k == 100) || (stall_last && k == N - 1))
        repeat (7) step(1'b0, mod_sample(b, 8'(k)), 8'(k), b, 1'b0);
      step(1'b1, mod_sample(b, 8'(k)), 8'(k), b, 1'b0);
    end
  endtask

  task automatic send_word(input logic [11:0] wd, input bit stall);
    for (int i = 0; i < 12; i++) send_symbol(wd[i], stall && i == 2, stall && i == 7);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_out"}, bit_out, 0);
    check({tag, "_bit_valid"}, bit_valid, 0);
    check({tag, "_sym_weak"}, sym_weak, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_data_weak"}, data_weak, 0);
  endtask

  exp_t mon_e;
  // Monitor: compare every presented pulse, and flag expected pulses that never came.
  always @(negedge clk) begin
    if (rst) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) check("bit_unexpected", bit_valid, 0);
        else begin
          mon_e = bit_q.pop_front();
          check("bit_out", bit_out, mon_e.v[0]);
          check("sym_weak", sym_weak, mon_e.w);
          check("bit_cycle", cyc, mon_e.due);
        end
      end else if (bit_q.size() > 0 && bit_q[0].due <= cyc) begin
        mon_e = bit_q.pop_front();
        check("bit_valid_missing", bit_valid, 1);
      end
      if (data_valid) begin
        if (word_q.size() == 0) check("data_unexpected", data_valid, 0);
        else begin
          mon_e = word_q.pop_front();
          check("data_out", data_out, mon_e.v);
          check("data_weak", data_weak, mon_e.w);
          check("data_cycle", cyc, mon_e.due);
        end
      end else if (word_q.size() > 0 && word_q[0].due <= cyc) begin
        mon_e = word_q.pop_front();
        check("data_valid_missing", data_valid, 1);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Stream joins mid-period at phase 100: those samples must be ignored.
    for (int k = 100; k < N; k++) step(1'b1, mod_sample(1'b0, 8'(k)), 8'(k), 1'b0, 1'b0);
    send_word(12'hA5C, 1'b0);
    send_word(12'h000, 1'b0);
    send_word(12'hFFF, 1'b0);
    send_word(12'h3C6, 1'b1);

    // Midscale input correlates to exactly zero: sliced as 1, flagged weak.
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < N; k++) step(1'b1, 12'h800, 8'(k), 1'b1, 1'b1);
    send_word(12'h5A3, 1'b0);

    // Reset during symbol 5 of a word; resync at the next period start.
    for (int i = 0; i < 5; i++) send_symbol(12'h96A >> i, 1'b0, 1'b0);
    for (int k = 0; k < 77; k++) step(1'b1, mod_sample(1'b1, 8'(k)), 8'(k), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    #1 check_all_zero("midreset");
    pend_q.delete();
    bit_q.delete();
    word_q.delete();
    synced_b = 1'b0;
    bitcnt_b = 0;
    wstick_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 77; k < N; k++) step(1'b1, mod_sample(1'b1, 8'(k)), 8'(k), 1'b1, 1'b0);
    send_word(12'h96A, 1'b0);

    for (int k = 0; k < 4; k++) step(1'b1, 12'h800, 8'(k), 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("pending_left", pend_q.size(), 0);
    check("bits_left", bit_q.size(), 0);
    check("words_left", word_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
